// File: rtl/pt_walk_arbiter_if.sv
// Bundle of the two MMU walker request/response channels and the page-table memory read port.
interface pt_walk_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic                  rsp0_error;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;
  logic                  rsp1_error;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, mem_data, mem_ready,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_error,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_error,
    output mem_addr, mem_read
  );

  // Walkers plus memory side
  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, mem_data, mem_ready,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_error,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_error,
    input  mem_addr, mem_read
  );
endinterface

// File: rtl/pt_walk_arbiter.sv
// Round-robin arbiter sharing one page-table memory read port between the instruction and data MMU walkers.
module pt_walk_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  pt_walk_arbiter_if.slave   bus,
  output logic               busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic gnt0, gnt1;
  logic rsp0_vld, rsp1_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          addr_d  = gnt1 ? bus.req1_addr : bus.req0_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready arriving on the last allowed cycle still counts as success.
        if (bus.mem_ready) begin
          data_d  = bus.mem_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // Readies are masked during reset so a walker never sees a handshake that the reset discards.
    if (state_q == IDLE && !rst) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
    rsp0_vld = (state_q == RESP) && !owner_q;
    rsp1_vld = (state_q == RESP) &&  owner_q;

    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.rsp0_valid = rsp0_vld;
    bus.rsp1_valid = rsp1_vld;
    bus.rsp0_data  = data_q;
    bus.rsp1_data  = data_q;
    bus.rsp0_error = rsp0_vld && err_q;
    bus.rsp1_error = rsp1_vld && err_q;
    bus.mem_read   = (state_q == ISSUE);
    bus.mem_addr   = addr_q;
    busy           = (state_q != IDLE);
  end

endmodule
